// File: rtl/half_adder_pipe.sv
// half_adder_pipe
//   Vectorised half adder: WIDTH independent lanes, each producing
//   s[i] = a[i] ^ b[i] and c[i] = a[i] & b[i]. Lanes do not interact.
//   {c[i], s[i]} is always the exact 2-bit sum of a[i] + b[i].
//   With REG_OUT=1 the results are registered (1-cycle latency) and
//   qualified by out_valid. With REG_OUT=0 the cell is purely combinational.
//
// Parameters
//   WIDTH    number of half-adder lanes (>= 1)
//   REG_OUT  1: registered outputs, 0: combinational outputs
//
// Ports
//   clk        in   rising-edge clock (unused when REG_OUT=0)
//   rst_n      in   asynchronous active-low reset (unused when REG_OUT=0)
//   in_valid   in   a/b hold a valid operand pair this cycle
//   a, b       in   lane-wise operands
//   s          out  lane-wise sum bits
//   c          out  lane-wise carry bits
//   out_valid  out  s/c are valid
module half_adder_pipe #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c,
  output logic             out_valid
);

  // Lane results. Plain bitwise operators keep X/Z on a/b visible at s/c.
  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] c_d;

  always_comb begin
    s_d = a ^ b;
    c_d = a & b;
  end

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             valid_q;

    // s/c only load on valid inputs so the last result stays visible while
    // out_valid is low; out_valid itself tracks in_valid every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q     <= '0;
        c_q     <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= in_valid;
        if (in_valid) begin
          s_q <= s_d;
          c_q <= c_d;
        end
      end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign s         = s_d;
    assign c         = c_d;
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_half_adder_pipe.sv
// Testbench for half_adder_pipe.
//   dut4 : WIDTH=4, REG_OUT=1
//   dut1 : WIDTH=1, REG_OUT=1 (shares clk/rst_n/in_valid with dut4)
//   dutc : WIDTH=2, REG_OUT=0
// Registered DUTs are checked through a scoreboard queue: the stimulus
// pushes one hand-computed expectation per clock edge it drives, and a
// monitor pops and compares on every falling edge.
module tb_half_adder_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a4, b4, s4, c4;
  logic       a1, b1, s1, c1;
  logic       ov4, ov1;
  logic [1:0] ac, bc, sc, cc;
  logic       vc, ovc;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct packed {
    logic       v;
    logic [3:0] s4;
    logic [3:0] c4;
    logic       s1;
    logic       c1;
  } exp_t;

  exp_t sb[$];

  half_adder_pipe #(.WIDTH(4), .REG_OUT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a4), .b(b4), .s(s4), .c(c4), .out_valid(ov4)
  );

  half_adder_pipe #(.WIDTH(1), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a1), .b(b1), .s(s1), .c(c1), .out_valid(ov1)
  );

  half_adder_pipe #(.WIDTH(2), .REG_OUT(0)) dutc (
    .clk(clk), .rst_n(rst_n), .in_valid(vc),
    .a(ac), .b(bc), .s(sc), .c(cc), .out_valid(ovc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Drive one vector, let the next rising edge sample it, then queue the
  // expected registered outputs for the monitor.
  task automatic step(input logic v, input logic [3:0] ia4, input logic [3:0] ib4,
                      input logic ia1, input logic ib1,
                      input logic ev, input logic [3:0] es4, input logic [3:0] ec4,
                      input logic es1, input logic ec1);
    exp_t e;
    in_valid = v;
    a4 = ia4; b4 = ib4;
    a1 = ia1; b1 = ib1;
    @(posedge clk);
    e.v = ev; e.s4 = es4; e.c4 = ec4; e.s1 = es1; e.c1 = ec1;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compare whatever the registered DUTs present on each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_total++;
      if ({ov4, s4, c4, ov1, s1, c1} !== {e.v, e.s4, e.c4, e.v, e.s1, e.c1})
        $display("FAIL scoreboard: got v4=%b s4=%b c4=%b v1=%b s1=%b c1=%b expected v=%b s4=%b c4=%b s1=%b c1=%b",
                 ov4, s4, c4, ov1, s1, c1, e.v, e.s4, e.c4, e.s1, e.c1);
      else
        n_pass++;
    end else if (ov4 !== 1'b0 || ov1 !== 1'b0) begin
      n_total++;
      $display("FAIL unexpected_valid: got ov4=%b ov1=%b expected 0 0", ov4, ov1);
    end
  end

  initial begin
    int unsigned wait_cycles;
    rst_n = 1'b1;
    in_valid = 1'b1;
    a4 = 4'b1111; b4 = 4'b1111; a1 = 1'b1; b1 = 1'b1;
    ac = '0; bc = '0; vc = 1'b0;

    // Asynchronous reset with all-ones operands, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async_w4", {23'd0, ov4, s4, c4}, 32'd0);
    chk("reset_async_w1", {29'd0, ov1, s1, c1}, 32'd0);

    // Still cleared after a rising edge while reset is held.
    @(posedge clk);
    #1;
    chk("reset_held_w4", {23'd0, ov4, s4, c4}, 32'd0);
    chk("reset_held_w1", {29'd0, ov1, s1, c1}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    //    v  a4       b4       a1    b1      ev  s4       c4       s1    c1
    step(1, 4'b0000, 4'b0000, 1'b0, 1'b0,   1, 4'b0000, 4'b0000, 1'b0, 1'b0);
    step(1, 4'b0011, 4'b0101, 1'b0, 1'b1,   1, 4'b0110, 4'b0001, 1'b1, 1'b0);
    step(1, 4'b1100, 4'b1010, 1'b1, 1'b0,   1, 4'b0110, 4'b1000, 1'b1, 1'b0);
    step(1, 4'b1111, 4'b1111, 1'b1, 1'b1,   1, 4'b0000, 4'b1111, 1'b0, 1'b1);
    // in_valid dropped: out_valid falls, last result held despite new operands.
    step(0, 4'b0101, 4'b0000, 1'b0, 1'b0,   0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    step(0, 4'b0101, 4'b0000, 1'b0, 1'b0,   0, 4'b0000, 4'b1111, 1'b0, 1'b1);
    step(1, 4'b1001, 4'b0110, 1'b1, 1'b1,   1, 4'b1111, 4'b0000, 1'b0, 1'b1);
    step(1, 4'b0110, 4'b0110, 1'b0, 1'b0,   1, 4'b0000, 4'b0110, 1'b0, 1'b0);

    // Mid-stream reset: a valid result is captured, then reset wipes it
    // before it is ever observed.
    in_valid = 1'b1;
    a4 = 4'b1111; b4 = 4'b0001; a1 = 1'b1; b1 = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_w4", {23'd0, ov4, s4, c4}, 32'd0);
    chk("midreset_w1", {29'd0, ov1, s1, c1}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(1, 4'b1010, 4'b0011, 1'b0, 1'b1,   1, 4'b1001, 4'b0010, 1'b1, 1'b0);
    step(0, 4'b0000, 4'b0000, 1'b0, 1'b0,   0, 4'b1001, 4'b0010, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end

    // Combinational variant: full sweep of 2-bit operands, no clock involvement.
    for (int i = 0; i < 16; i++) begin
      ac = i[3:2];
      bc = i[1:0];
      vc = i[0] ^ i[2];
      #1;
      chk("comb_sc", {30'd0, sc}, {30'd0, ac ^ bc});
      chk("comb_cc", {30'd0, cc}, {30'd0, ac & bc});
      chk("comb_valid", {31'd0, ovc}, {31'd0, vc});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
